// File: rtl/mem_arbiter.sv
// Two-to-one memory port arbiter between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data priority with a starvation limit.
module mem_arbiter #(
    parameter int WIDTH          = 32,
    parameter int ADDR_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instruction_valid,
    input  logic [ADDR_W-1:0]    instruction_addr,
    output logic [WIDTH-1:0]     instruction_read,
    output logic                 instruction_ready,
    output logic                 instruction_ack,
    input  logic                 data_read_valid,
    input  logic                 data_write_valid,
    input  logic [ADDR_W-1:0]    data_addr,
    input  logic [WIDTH-1:0]     data_write,
    input  logic [WIDTH/8-1:0]   data_write_byte,
    output logic [WIDTH-1:0]     data_read,
    output logic                 data_ready,
    output logic                 data_ack,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic [WIDTH/8-1:0]   mem_wstrb,
    input  logic [WIDTH-1:0]     mem_rdata,
    input  logic                 mem_ready,
    input  logic                 mem_ack
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam logic GNT_D = 1'b0;
    localparam logic GNT_I = 1'b1;

    state_t               state, state_nx;
    logic                 grant;
    logic [ADDR_W-1:0]    lat_addr;
    logic [WIDTH-1:0]     lat_wdata;
    logic [WIDTH/8-1:0]   lat_wstrb;
    logic                 lat_rd, lat_wr;
    logic                 i_req, d_req, pick_i, ack_fwd, rdy_fwd;

    assign i_req = instruction_valid;
    assign d_req = data_read_valid | data_write_valid;

`ifdef MEM_ARB_RR_EN
    // On contention the side that did not win last time goes next.
    assign pick_i = i_req && (!d_req || grant == GNT_D);
`else
    localparam logic [3:0] BURST_LIM = 4'(MAX_DATA_BURST);
    logic [3:0] burst_cnt;

    assign pick_i = i_req && (!d_req || burst_cnt == BURST_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            burst_cnt <= '0;
        else if (state == IDLE && (i_req || d_req)) begin
            if (pick_i)
                burst_cnt <= '0;
            else if (i_req && burst_cnt != 4'hF)
                burst_cnt <= burst_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= GNT_D;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (i_req || d_req)) begin
                grant <= pick_i;
                if (pick_i) begin
                    lat_addr  <= instruction_addr;
                    lat_wdata <= '0;
                    lat_wstrb <= '0;
                    lat_rd    <= 1'b1;
                    lat_wr    <= 1'b0;
                end else begin
                    // A simultaneous read+write request is served as the write.
                    lat_addr  <= data_addr;
                    lat_wdata <= data_write_valid ? data_write : '0;
                    lat_wstrb <= data_write_valid ? data_write_byte : '0;
                    lat_rd    <= !data_write_valid;
                    lat_wr    <= data_write_valid;
                end
            end
        end
    end

    always_comb begin
        state_nx  = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        ack_fwd   = 1'b0;
        rdy_fwd   = 1'b0;
        case (state)
            IDLE: if (i_req || d_req) state_nx = ISSUE;
            ISSUE: begin
                mem_read  = lat_rd;
                mem_write = lat_wr;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                mem_wstrb = lat_wstrb;
                ack_fwd   = mem_ack;
                rdy_fwd   = mem_ack & mem_ready;
                if (mem_ack) state_nx = mem_ready ? IDLE : WAIT;
            end
            WAIT: begin
                rdy_fwd = mem_ready;
                if (mem_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign instruction_ack   = ack_fwd & (grant == GNT_I);
    assign data_ack          = ack_fwd & (grant == GNT_D);
    assign instruction_ready = rdy_fwd & (grant == GNT_I);
    assign data_ready        = rdy_fwd & (grant == GNT_D);
    assign instruction_read  = instruction_ready ? mem_rdata : '0;
    assign data_read         = data_ready ? mem_rdata : '0;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one arbiter that shares a single memory port between the riscv32 core's instruction-fetch port and its data port. It sits between the core and one `memory` instance, and replaces the current duplicated wiring. Each request is latched, forwarded to memory, and the memory's `ack`/`ready` are routed back to the granted requester. Fixed data-priority arbitration carries a starvation limit; round-robin arbitration is a build option.

## Interface

Parameters:
- `WIDTH`, 32: data width.
- `ADDR_W`, 32: address width.
- `MAX_DATA_BURST`, 4: consecutive data grants allowed while a fetch is pending (fixed-priority mode only), range 1–15.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instruction_valid`  in  1  fetch request; held until `instruction_ack`.
- `instruction_addr`  in  ADDR_W  fetch address.
- `instruction_read`  out  WIDTH  fetch data; valid when `instruction_ready`.
- `instruction_ready`  out  1  fetch data valid (1-cycle pulse).
- `instruction_ack`  out  1  fetch request accepted (1-cycle pulse).
- `data_read_valid`  in  1  load request.
- `data_write_valid`  in  1  store request.
- `data_addr`  in  ADDR_W  load/store address.
- `data_write`  in  WIDTH  store data.
- `data_write_byte`  in  WIDTH/8  store byte strobes.
- `data_read`  out  WIDTH  load data; valid when `data_ready`.
- `data_ready`  out  1  load/store complete (1-cycle pulse).
- `data_ack`  out  1  load/store accepted (1-cycle pulse).
- `mem_read`, `mem_write`  out  1  memory request strobes.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  WIDTH  memory write data.
- `mem_wstrb`  out  WIDTH/8  memory byte strobes.
- `mem_rdata`  in  WIDTH  memory read data.
- `mem_ready`  in  1  memory finished the access.
- `mem_ack`  in  1  memory accepted the request.

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - On any pending request, select a winner and latch its address, write data, strobes and operation into registers.
  - Record the winner as `grant`, then go to ISSUE.
  - With no request pending, stay in IDLE.
- **ISSUE**
  - Drive `mem_*` from the latched registers.
  - `mem_ack` is forwarded combinationally to the granted requester's `*_ack`.
  - On `mem_ack`, go to WAIT.
  - If `mem_ack` and `mem_ready` arrive in the same cycle, forward both and go directly to IDLE.
- **WAIT**
  - `mem_read`/`mem_write` are deasserted.
  - `mem_ready` and `mem_rdata` are forwarded combinationally to the granted requester.
  - On `mem_ready`, go to IDLE.
- The non-granted requester never sees `ack` or `ready`. Its request stays pending and is re-arbitrated in IDLE.
- If `data_read_valid` and `data_write_valid` are both high, the access is treated as a write and the read is ignored.
- For a fetch, `mem_write` = 0 and `mem_wstrb` = 0.
- **Fixed priority (default)**
  - Data wins contention.
  - A 4-bit `burst_cnt` counts data grants issued while `instruction_valid` is high.
  - When `burst_cnt` == `MAX_DATA_BURST`, the next contention goes to instruction and `burst_cnt` clears.
  - `burst_cnt` also clears on any instruction grant.
  - `burst_cnt` saturates and never wraps.

## Timing

- **Reset** (asynchronous, immediate):
  - State returns to IDLE; `grant` = data; `burst_cnt` = 0; latched registers = 0.
  - All outputs are 0: `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `mem_wstrb`, every `*_ack`, every `*_ready`, `instruction_read`, `data_read`.
  - An access in flight is abandoned. A late `mem_ready` arriving after reset is ignored while in IDLE.
- **Latency**
  - A request sampled in IDLE at edge N drives `mem_*` in cycle N+1.
  - Best case is `ready` in cycle N+1 (same-cycle ack/ready), i.e. 1 cycle after the sampling edge.
  - Arbitration overhead is one IDLE cycle between back-to-back transactions.
- `*_read` outputs are 0 whenever the matching `*_ready` is 0.

## Configuration

- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration: on contention, the requester not granted last wins.
  - `burst_cnt` and `MAX_DATA_BURST` are unused.
- `MEM_ARB_RR_EN` undefined: fixed data priority with the starvation limit, as above.

## Test plan

- Fetch only, `instruction_addr`=0x00010000, memory acks and readies 1 cycle later with 0x00000013 → one `instruction_ack` pulse, then one `instruction_ready` pulse with `instruction_read`=0x00000013; `data_ack`/`data_ready` stay 0.
- Store to 0x100, data 0xDEADBEEF, strobe 0x3, with same-cycle `mem_ack`+`mem_ready` → `mem_write`=1 for 1 cycle with those values; `data_ack` and `data_ready` pulse together; state returns to IDLE.
- Fetch and load held continuously, fixed priority, `MAX_DATA_BURST`=4 → grant order D,D,D,D,I repeating.
- Same stimulus with `MEM_ARB_RR_EN` defined → grant order alternates D,I,D,I.
- Both `data_read_valid` and `data_write_valid` high → `mem_write`=1 and `mem_read`=0.
- Assert `reset` during WAIT, then deliver `mem_ready` → all outputs read 0 immediately; no `*_ready` is forwarded; the next request is served normally.
